rx_serial_servo: RTL

Asynchronous serial receiver (UART RX, 8N1; 8E1 with parity built in) for the servo test datapath. It is the receive end of the serial link whose transmit side is driven by the servo test control unit. It oversamples the RX line with a baud tick counter and delivers a byte on `dado_recebido` with a one-cycle `pronto_rx` strobe, which drives the control unit's `fim_rx`. It holds a `tem_dado` flag until the consumer acknowledges the byte.

---
 rtl/rx_serial_servo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rx_serial_servo.sv
// rtl/rx_serial_servo.sv - UART receiver (8N1; 8E1 when RX_PARITY_EN is defined) for the servo test link
module rx_serial_servo #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       recebe_dado,
  output logic [7:0] dado_recebido,
  output logic       pronto_rx,
  output logic       tem_dado,
  output logic       erro_quadro,
  output logic       erro_paridade,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 2);

`ifdef RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  localparam logic [3:0] INICIAL       = 4'h0;
  localparam logic [3:0] PREPARACAO    = 4'h1;
  localparam logic [3:0] MEIO_START    = 4'h2;
  localparam logic [3:0] ESPERA_BIT    = 4'h3;
  localparam logic [3:0] AMOSTRA       = 4'h4;
  localparam logic [3:0] VERIFICA_STOP = 4'h5;
  localparam logic [3:0] ARMAZENA      = 4'h6;
  localparam logic [3:0] FINAL_RX      = 4'hF;

  logic             rx_meta;
  logic             rx_s;
  logic [3:0]       estado;
  logic [3:0]       proximo;
  logic [TW-1:0]    tick;
  logic [3:0]       bit_cnt;
  logic [NBITS-1:0] shift_reg;
  logic             stop_bit;
  logic             armado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:       if (!rx_s && armado) proximo = PREPARACAO;
      PREPARACAO:    proximo = MEIO_START;
      MEIO_START:    if (tick == HALF_END) proximo = rx_s ? INICIAL : ESPERA_BIT;
      ESPERA_BIT:    if (tick == BIT_END)
                       proximo = (bit_cnt == 4'(NBITS)) ? VERIFICA_STOP : AMOSTRA;
      AMOSTRA:       proximo = ESPERA_BIT;
      VERIFICA_STOP: proximo = ARMAZENA;
      ARMAZENA:      proximo = FINAL_RX;
      FINAL_RX:      proximo = INICIAL;
      default:       proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
      tick   <= '0;
    end else begin
      estado <= proximo;
      // Counter restarts on every entry into a counting state
      if ((estado == MEIO_START || estado == ESPERA_BIT) && proximo == estado)
        tick <= tick + 1'b1;
      else
        tick <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      stop_bit  <= 1'b1;
    end else begin
      if (estado == PREPARACAO)
        bit_cnt <= '0;
      else if (estado == AMOSTRA)
        bit_cnt <= bit_cnt + 1'b1;
      if (estado == AMOSTRA)
        shift_reg <= {rx_s, shift_reg[NBITS-1:1]};
      if (estado == VERIFICA_STOP)
        stop_bit <= rx_s;
    end
  end

  // A low stop bit disarms start detection until the line is seen high again,
  // so a held break does not restart a frame every few cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      armado <= 1'b1;
    else if (estado == VERIFICA_STOP)
      armado <= rx_s;
    else if (estado == INICIAL && rx_s)
      armado <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado_recebido <= 8'h00;
      erro_quadro   <= 1'b0;
      tem_dado      <= 1'b0;
    end else begin
      if (estado == ARMAZENA) begin
        dado_recebido <= shift_reg[7:0];
        erro_quadro   <= ~stop_bit;
        tem_dado      <= 1'b1;
      end else if (recebe_dado) begin
        tem_dado <= 1'b0;
      end
    end
  end

`ifdef RX_PARITY_EN
  // Even parity: XOR over data plus parity bit is 1 on error
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      erro_paridade <= 1'b0;
    else if (estado == ARMAZENA)
      erro_paridade <= ^shift_reg;
  end
`else
  assign erro_paridade = 1'b0;
`endif

  assign pronto_rx = (estado == FINAL_RX);

  always_comb begin
    case (estado)
      INICIAL, PREPARACAO, MEIO_START, ESPERA_BIT, AMOSTRA,
      VERIFICA_STOP, ARMAZENA, FINAL_RX: db_estado = estado;
      default:                            db_estado = 4'hE;
    endcase
  end

endmodule
